// File: rtl/cpu_mem_loader_if.sv
`default_nettype none
// cpu_mem_loader_if: boot byte stream and cpu memory bus bundled for cpu_mem_loader.
// slave = memory/loader side, master = cpu plus boot source side.
interface cpu_mem_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  ld_start;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic                  busy;
  logic                  load_done;
  logic                  cpu_rst;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  modport slave (
    input  ld_start, ld_valid, ld_data, cpu_write, cpu_addr, cpu_wdata,
    output ld_ready, busy, load_done, cpu_rst, cpu_rdata
  );

  modport master (
    output ld_start, ld_valid, ld_data, cpu_write, cpu_addr, cpu_wdata,
    input  ld_ready, busy, load_done, cpu_rst, cpu_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_loader.sv
`default_nettype none
// cpu_mem_loader: cpu program/data memory that boots itself from a byte stream and holds
// the cpu in reset until loaded. Optional output latch at the top address: IO_PORT_EN.
module cpu_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LOAD_LEN   = 256
) (
  input  wire logic        clk,
  input  wire logic        rst,
  cpu_mem_loader_if.slave  bus
`ifdef IO_PORT_EN
  ,
  output logic [DATA_WIDTH-1:0] io_out
`endif
);

  localparam int                  c_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_LAST  = (ADDR_WIDTH + 1)'(LOAD_LEN - 1);
  localparam logic [ADDR_WIDTH:0] c_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic                  r_cpu_rst;
  logic                  r_busy;
  logic                  r_load_done;
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  logic w_accept;
  logic w_last;
  logic w_cpu_we;

  assign w_accept = bus.ld_valid && (r_state == S_LOAD);
  assign w_last   = (r_ptr == c_LAST);
  assign w_cpu_we = bus.cpu_write && (r_state == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cpu_rst   <= 1'b1;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.ld_start) begin
            r_state <= S_LOAD;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_ptr <= r_ptr + c_ONE;
            if (w_last) begin
              r_state     <= S_RUN;
              r_busy      <= 1'b0;
              r_cpu_rst   <= 1'b0;
              r_load_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.ld_start) begin
            r_state   <= S_LOAD;
            r_ptr     <= '0;
            r_busy    <= 1'b1;
            r_cpu_rst <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // No reset on the array: contents survive rst; writes are gated by state, which is reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_ptr[ADDR_WIDTH-1:0]] <= bus.ld_data;
    end else if (w_cpu_we) begin
      r_mem[bus.cpu_addr] <= bus.cpu_wdata;
    end
  end

  // Zero-latency read: the cpu forms its next address from rdata in the same cycle.
  assign bus.cpu_rdata = (r_state == S_RUN) ? r_mem[bus.cpu_addr] : '0;
  assign bus.ld_ready  = (r_state == S_LOAD);
  assign bus.busy      = r_busy;
  assign bus.load_done = r_load_done;
  assign bus.cpu_rst   = r_cpu_rst;

`ifdef IO_PORT_EN
  logic [DATA_WIDTH-1:0] r_io;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_io <= '0;
    end else if (w_cpu_we && (bus.cpu_addr == {ADDR_WIDTH{1'b1}})) begin
      r_io <= bus.cpu_wdata;
    end
  end

  assign io_out = r_io;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_loader.sv
`default_nettype none
// tb_cpu_mem_loader: scenario tasks plus randomized traffic checked against an
// array model of memory contents (LOAD_LEN=4).
module tb_cpu_mem_loader;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef IO_PORT_EN
  logic [DW-1:0] io_out;
  logic [DW-1:0] io_mdl;
`endif

  cpu_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_LEN(LL)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus)
`ifdef IO_PORT_EN
    ,
    .io_out (io_out)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl      [256];
  bit         known    [256];
  logic [7:0] load_buf [LL];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic start_load();
    @(negedge clk);
    bus.ld_start = 1'b1;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_load: busy=%b cpu_rst=%b ready=%b, required 1 1 1",
               bus.busy, bus.cpu_rst, bus.ld_ready);
    end
  endtask

  // Streams load_buf while the cpu hammers wr_addr; those writes must be ignored.
  task automatic run_load(input bit rnd, input logic [7:0] wr_addr);
    int acc = 0;
    int cyc = 0;
    int gap = 0;
    bit v;
    while (acc < LL && cyc < 400) begin
      if (rnd) v = ($urandom_range(0, 2) != 0);
      else begin
        v = !(acc == 2 && gap < 2);
        if (!v) gap++;
      end
      bus.ld_valid  = v;
      bus.ld_data   = load_buf[acc];
      bus.cpu_write = 1'b1;
      bus.cpu_addr  = wr_addr;
      bus.cpu_wdata = 8'hEE;
      #1;
      checks++;
      if (bus.ld_ready !== 1'b1 || bus.busy !== 1'b1 || bus.cpu_rst !== 1'b1 ||
          bus.load_done !== 1'b0 || bus.cpu_rdata !== 8'h00) begin
        errors++;
        $display("FAIL load_phase: ready=%b busy=%b cpu_rst=%b done=%b rdata=%h, required 1 1 1 0 00",
                 bus.ld_ready, bus.busy, bus.cpu_rst, bus.load_done, bus.cpu_rdata);
      end
      @(posedge clk); #1;
      if (v) acc++;
      cyc++;
    end
    bus.ld_valid  = 1'b0;
    bus.cpu_write = 1'b0;
    if (acc < LL) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d, required %0d", acc, LL);
    end
    for (int i = 0; i < LL; i++) begin
      mdl[i]   = load_buf[i];
      known[i] = 1'b1;
    end
    checks++;
    if (bus.load_done !== 1'b1 || bus.cpu_rst !== 1'b0 || bus.busy !== 1'b0 || bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_end: done=%b cpu_rst=%b busy=%b ready=%b, required 1 0 0 0",
               bus.load_done, bus.cpu_rst, bus.busy, bus.ld_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.load_done !== 1'b0 || bus.cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b cpu_rst=%b, required 0 0", bus.load_done, bus.cpu_rst);
    end
  endtask

  task automatic test_reset();
    logic [7:0] a;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      bus.cpu_addr = a;
      #1;
      checks++;
      if (bus.cpu_rst !== 1'b1 || bus.ld_ready !== 1'b0 || bus.busy !== 1'b0 ||
          bus.load_done !== 1'b0 || bus.cpu_rdata !== 8'h00) begin
        errors++;
        $display("FAIL reset_state: addr=%h cpu_rst=%b ready=%b busy=%b done=%b rdata=%h, required 1 0 0 0 00",
                 a, bus.cpu_rst, bus.ld_ready, bus.busy, bus.load_done, bus.cpu_rdata);
      end
`ifdef IO_PORT_EN
      checks++;
      if (io_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_io: io_out=%h, required 00", io_out);
      end
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: ready=%b cpu_rst=%b, required 0 1", bus.ld_ready, bus.cpu_rst);
    end
  endtask

  task automatic test_load();
    load_buf = '{8'h01, 8'h0A, 8'h0B, 8'h08};
    start_load();
    run_load(1'b0, 8'h02);
    for (int i = 0; i < LL; i++) begin
      @(negedge clk);
      bus.cpu_addr = 8'(i);
      #1;
      checks++;
      if (bus.cpu_rdata !== load_buf[i]) begin
        errors++;
        $display("FAIL load_read: addr=%0d rdata=%h, required %h", i, bus.cpu_rdata, load_buf[i]);
      end
    end
  endtask

  task automatic test_run_write();
    @(negedge clk);
    bus.cpu_addr = 8'h20; bus.cpu_wdata = 8'h5A; bus.cpu_write = 1'b1;
    @(negedge clk);
    bus.cpu_wdata = 8'h55;
    #1;
    checks++;
    if (bus.cpu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL write_old_data: rdata=%h, required 5A", bus.cpu_rdata);
    end
    @(posedge clk); #1;
    bus.cpu_write = 1'b0;
    checks++;
    if (bus.cpu_rdata !== 8'h55) begin
      errors++;
      $display("FAIL write_new_data: rdata=%h, required 55", bus.cpu_rdata);
    end
    mdl[8'h20] = 8'h55; known[8'h20] = 1'b1;
  endtask

  task automatic test_reload();
    @(negedge clk);
    bus.ld_start = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 8'h40; bus.cpu_wdata = 8'h77;
    @(posedge clk); #1;
    bus.ld_start = 1'b0; bus.cpu_write = 1'b0;
    mdl[8'h40] = 8'h77; known[8'h40] = 1'b1;
    checks++;
    if (bus.cpu_rst !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_enter: cpu_rst=%b busy=%b, required 1 1", bus.cpu_rst, bus.busy);
    end
    load_buf = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1'b1, 8'h20);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a;
      a = (i < 4) ? 8'(i) : ((i == 4) ? 8'h20 : 8'h40);
      @(negedge clk);
      bus.cpu_addr = a;
      #1;
      checks++;
      if (bus.cpu_rdata !== mdl[a]) begin
        errors++;
        $display("FAIL reload_read: addr=%h rdata=%h, required %h", a, bus.cpu_rdata, mdl[a]);
      end
    end
  endtask

`ifdef IO_PORT_EN
  task automatic test_io();
    @(negedge clk);
    bus.cpu_addr = 8'hFF; bus.cpu_wdata = 8'h3C; bus.cpu_write = 1'b1;
    @(posedge clk); #1;
    bus.cpu_write = 1'b0;
    io_mdl = 8'h3C; mdl[8'hFF] = 8'h3C; known[8'hFF] = 1'b1;
    @(negedge clk);
    checks++;
    if (io_out !== 8'h3C || bus.cpu_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL io_write: io_out=%h rdata=%h, required 3C 3C", io_out, bus.cpu_rdata);
    end
    for (int i = 0; i < LL; i++) load_buf[i] = 8'($urandom);
    start_load();
    run_load(1'b1, 8'hFF);
    checks++;
    if (io_out !== 8'h3C) begin
      errors++;
      $display("FAIL io_reload: io_out=%h, required 3C", io_out);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    io_mdl = 8'h00;
    checks++;
    if (io_out !== 8'h00 || bus.cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL io_rst: io_out=%h cpu_rst=%b, required 00 1", io_out, bus.cpu_rst);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] d;
    bit w;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < LL; i++) load_buf[i] = 8'($urandom);
      start_load();
      run_load(1'b1, 8'($urandom_range(4, 255)));
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(240, 255));
        w = ($urandom_range(0, 1) != 0);
        d = 8'($urandom);
        bus.cpu_addr = a; bus.cpu_write = w; bus.cpu_wdata = d;
        #1;
        if (known[a]) begin
          checks++;
          if (bus.cpu_rdata !== mdl[a]) begin
            errors++;
            $display("FAIL rand_read: addr=%h rdata=%h, required %h", a, bus.cpu_rdata, mdl[a]);
          end
        end
        @(posedge clk); #1;
        bus.cpu_write = 1'b0;
        if (w) begin
          mdl[a] = d; known[a] = 1'b1;
`ifdef IO_PORT_EN
          if (a == 8'hFF) io_mdl = d;
`endif
        end
`ifdef IO_PORT_EN
        checks++;
        if (io_out !== io_mdl) begin
          errors++;
          $display("FAIL rand_io: io_out=%h, required %h", io_out, io_mdl);
        end
`endif
      end
    end
  endtask

  task automatic test_rst_mid_load();
    logic [7:0] keep2;
    logic [7:0] keep3;
    keep2 = mdl[2];
    keep3 = mdl[3];
    start_load();
    bus.ld_valid = 1'b1; bus.ld_data = 8'hAA;
    @(posedge clk); #1;
    bus.ld_data = 8'hBB;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    rst = 1'b1;
    #1;
    mdl[0] = 8'hAA; mdl[1] = 8'hBB;
`ifdef IO_PORT_EN
    io_mdl = 8'h00;
`endif
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_load: ready=%b busy=%b cpu_rst=%b, required 0 0 1",
               bus.ld_ready, bus.busy, bus.cpu_rst);
    end
    checks++;
    if (dut.r_mem[0] !== 8'hAA || dut.r_mem[1] !== 8'hBB ||
        dut.r_mem[2] !== keep2 || dut.r_mem[3] !== keep3) begin
      errors++;
      $display("FAIL rst_mem_keep: mem0..3=%h %h %h %h, required AA BB %h %h",
               dut.r_mem[0], dut.r_mem[1], dut.r_mem[2], dut.r_mem[3], keep2, keep3);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: ready=%b, required 0", bus.ld_ready);
    end
    for (int i = 0; i < LL; i++) load_buf[i] = 8'($urandom);
    start_load();
    run_load(1'b1, 8'h10);
    for (int i = 0; i < LL; i++) begin
      @(negedge clk);
      bus.cpu_addr = 8'(i);
      #1;
      checks++;
      if (bus.cpu_rdata !== load_buf[i]) begin
        errors++;
        $display("FAIL post_rst_load: addr=%0d rdata=%h, required %h", i, bus.cpu_rdata, load_buf[i]);
      end
    end
  endtask

  initial begin
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0;
    bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      known[i] = 1'b0;
      mdl[i]   = '0;
    end
`ifdef IO_PORT_EN
    io_mdl = 8'h00;
`endif
    test_reset();
    test_load();
    test_run_write();
    test_reload();
`ifdef IO_PORT_EN
    test_io();
`endif
    test_random();
    test_rst_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
